// File: rtl/pdm_mic_receiver.sv
// -----------------------------------------------------------------------------
// pdm_mic_receiver
// Clock-master reader for a PDM microphone. Divides clk down to the mic bit
// clock, samples the synchronised PDM stream on each falling m_clk, counts
// the 1-bits over fixed windows of DEC bits and hands each count out as an
// unsigned PCM sample through a valid/ready handshake.
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst_n        in   asynchronous reset, active low
//   enable       in   1 = run m_clk and capture, 0 = idle with window cleared
//   pdm_data     in   mic data, asynchronous to clk
//   m_clk        out  mic bit clock (registered)
//   sample_data  out  1-bit count of the last completed window (0..DEC)
//   sample_valid out  sample_data holds an unconsumed sample
//   sample_ready in   consumer accepts sample when valid && ready
//   overrun      out  sticky: an unconsumed sample was overwritten
//   clr_overrun  in   synchronous clear of overrun
// -----------------------------------------------------------------------------
module pdm_mic_receiver #(
    parameter int CLK_DIV  = 4,
    parameter int DEC      = 64,
    parameter int SAMPLE_W = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                pdm_data,
    output logic                m_clk,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    input  logic                clr_overrun
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DEC);

    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0]    BIT_LAST = CNT_W'(DEC - 1);
    localparam logic [CNT_W-1:0]    BIT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nx;
    logic                  run_s;

    logic                  pdm_meta_r;
    logic                  pdm_s_r;
    logic [SAMPLE_W-1:0]   pdm_ext_s;

    logic [DIV_W-1:0]      div_cnt_r;
    logic [DIV_W-1:0]      div_cnt_nx;
    logic                  m_clk_r;
    logic                  m_clk_nx;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [CNT_W-1:0]      bit_cnt_nx;
    logic [SAMPLE_W-1:0]   acc_r;
    logic [SAMPLE_W-1:0]   acc_nx;
    logic [SAMPLE_W-1:0]   sample_data_r;
    logic [SAMPLE_W-1:0]   sample_data_nx;
    logic                  sample_valid_r;
    logic                  sample_valid_nx;
    logic                  overrun_r;
    logic                  overrun_nx;
    logic                  load_s;

    assign pdm_ext_s = {{(SAMPLE_W - 1){1'b0}}, pdm_s_r};

    // Two-flop synchroniser for the asynchronous mic data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_meta_r <= 1'b0;
            pdm_s_r    <= 1'b0;
        end else begin
            pdm_meta_r <= pdm_data;
            pdm_s_r    <= pdm_meta_r;
        end
    end

    // Run/idle state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Run/idle next state; the datapath acts on the state being entered so
    // the first divider count happens on the first edge that sees enable=1.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        run_s = (state_nx == RUN);
    end

    // Divider, capture on the m_clk falling toggle, window accumulation,
    // output handshake and sticky overrun.
    always_comb begin
        div_cnt_nx      = div_cnt_r;
        m_clk_nx        = m_clk_r;
        bit_cnt_nx      = bit_cnt_r;
        acc_nx          = acc_r;
        sample_data_nx  = sample_data_r;
        sample_valid_nx = sample_valid_r;
        overrun_nx      = overrun_r;
        load_s          = 1'b0;

        if (!run_s) begin
            // Idle: any partial window is thrown away.
            div_cnt_nx = {DIV_W{1'b0}};
            m_clk_nx   = 1'b0;
            bit_cnt_nx = {CNT_W{1'b0}};
            acc_nx     = {SAMPLE_W{1'b0}};
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_nx = {DIV_W{1'b0}};
            m_clk_nx   = ~m_clk_r;
            if (m_clk_r) begin
                // Falling toggle: the mic launched on the rise, sample now.
                if (bit_cnt_r == BIT_LAST) begin
                    load_s     = 1'b1;
                    acc_nx     = {SAMPLE_W{1'b0}};
                    bit_cnt_nx = {CNT_W{1'b0}};
                end else begin
                    acc_nx     = acc_r + pdm_ext_s;
                    bit_cnt_nx = bit_cnt_r + BIT_ONE;
                end
            end else begin
                acc_nx     = acc_r;
                bit_cnt_nx = bit_cnt_r;
            end
        end else begin
            div_cnt_nx = div_cnt_r + DIV_ONE;
        end

        // A loading sample keeps valid high even if the old one is consumed.
        if (load_s) begin
            sample_data_nx  = acc_r + pdm_ext_s;
            sample_valid_nx = 1'b1;
        end else if (sample_valid_r && sample_ready) begin
            sample_valid_nx = 1'b0;
        end else begin
            sample_valid_nx = sample_valid_r;
        end

        // Setting has priority over the clear request.
        if (load_s && sample_valid_r && !sample_ready) begin
            overrun_nx = 1'b1;
        end else if (clr_overrun) begin
            overrun_nx = 1'b0;
        end else begin
            overrun_nx = overrun_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r      <= {DIV_W{1'b0}};
            m_clk_r        <= 1'b0;
            bit_cnt_r      <= {CNT_W{1'b0}};
            acc_r          <= {SAMPLE_W{1'b0}};
            sample_data_r  <= {SAMPLE_W{1'b0}};
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            div_cnt_r      <= div_cnt_nx;
            m_clk_r        <= m_clk_nx;
            bit_cnt_r      <= bit_cnt_nx;
            acc_r          <= acc_nx;
            sample_data_r  <= sample_data_nx;
            sample_valid_r <= sample_valid_nx;
            overrun_r      <= overrun_nx;
        end
    end

    assign m_clk        = m_clk_r;
    assign sample_data  = sample_data_r;
    assign sample_valid = sample_valid_r;
    assign overrun      = overrun_r;

endmodule
